// File: rtl/prbs11_slos_gen.sv
// Transmit-side SLOS1/SLOS2 generator: serializes 2048-bit PRBS11 frames, one bit per clk,
// under a start/stop/done burst handshake from the lane training FSM.
module prbs11_slos_gen #(
  parameter logic [10:0] SEED  = 11'h400,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic             slos_sel,
  input  logic [CNT_W-1:0] slos_count,
  output logic             data_out,
  output logic             tx_valid,
  output logic             slos_sent,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [10:0]      lfsr;
  logic [10:0]      bit_cnt;
  logic             inv;
  logic             stop_pend;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] frames;
  logic             last_bit;
  logic             finish;

  // bit_cnt is the index of the bit currently on data_out; lfsr holds the state for the next bit.
  assign last_bit  = (bit_cnt == 11'd2047);
  assign finish    = (count_q != '0) ? (frames == count_q) : (stop_pend | stop);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lfsr      <= SEED;
      bit_cnt   <= '0;
      inv       <= 1'b0;
      stop_pend <= 1'b0;
      count_q   <= '0;
      frames    <= '0;
      data_out  <= 1'b0;
      tx_valid  <= 1'b0;
      slos_sent <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (!enable) begin
      state     <= IDLE;
      lfsr      <= SEED;
      bit_cnt   <= '0;
      stop_pend <= 1'b0;
      frames    <= '0;
      data_out  <= 1'b0;
      tx_valid  <= 1'b0;
      slos_sent <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          data_out  <= 1'b0;
          tx_valid  <= 1'b0;
          slos_sent <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          if (start) begin
            state     <= SEND;
            count_q   <= slos_count;
            inv       <= slos_sel;
            stop_pend <= 1'b0;
            frames    <= '0;
            bit_cnt   <= '0;
            lfsr      <= SEED;
            data_out  <= SEED[0] ^ slos_sel;
            tx_valid  <= 1'b1;
            busy      <= 1'b1;
          end
        end

        SEND: begin
          if (count_q == '0 && stop) stop_pend <= 1'b1;
          if (last_bit) begin
            slos_sent <= 1'b0;
            if (finish) begin
              state    <= DONE;
              data_out <= 1'b0;
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              // Back-to-back frame: bit 0 restarts from SEED with a freshly sampled polarity.
              bit_cnt  <= '0;
              inv      <= slos_sel;
              lfsr     <= SEED;
              data_out <= SEED[0] ^ slos_sel;
            end
          end else begin
            bit_cnt   <= bit_cnt + 11'd1;
            data_out  <= lfsr[0] ^ inv;
            lfsr      <= {lfsr[9:0], lfsr[10] ^ lfsr[8]};
            slos_sent <= (bit_cnt == 11'd2046);
            if (bit_cnt == 11'd2046 && frames != '1)
              frames <= frames + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end

        DONE: begin
          state     <= IDLE;
          data_out  <= 1'b0;
          tx_valid  <= 1'b0;
          slos_sent <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          data_out <= 1'b0;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prbs11_slos_gen.sv
// Bench for prbs11_slos_gen: randomized bursts scored against a frame-level PRBS11 model.
module tb_prbs11_slos_gen;

  localparam logic [10:0] SEED  = 11'h400;
  localparam int          CNT_W = 16;

  // Clock / reset block
  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             slos_sel = 1'b0;
  logic [CNT_W-1:0] slos_count = '0;
  logic             data_out, tx_valid, slos_sent, busy, done;
  logic [1:0]       state_dbg;

  always #5 clk = ~clk;

  prbs11_slos_gen #(.SEED(SEED), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .start     (start),
    .stop      (stop),
    .slos_sel  (slos_sel),
    .slos_count(slos_count),
    .data_out  (data_out),
    .tx_valid  (tx_valid),
    .slos_sent (slos_sent),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // Scoreboard
  int         n_checks = 0;
  int         n_fail = 0;
  logic       golden [0:2047];
  logic [0:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // SLOS1 frame from the framing rule: SEED shown twice, then successive LFSR states.
  task automatic build_golden();
    logic [10:0] s;
    s = SEED;
    golden[0] = s[0];
    golden[1] = s[0];
    for (int i = 2; i < 2048; i++) begin
      s = {s[9:0], s[10] ^ s[8]};
      golden[i] = s[0];
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".data_out"},  data_out,  0);
    check({tag, ".tx_valid"},  tx_valid,  0);
    check({tag, ".slos_sent"}, slos_sent, 0);
    check({tag, ".busy"},      busy,      0);
    check({tag, ".done"},      done,      0);
  endtask

  // Driver + monitor for one burst. stop_at / abort_at are valid-bit indices (-1 = unused).
  task automatic burst(input string name, input int cnt, input bit sel0, input bit rand_sel,
                       input int stop_at, input int abort_at, input int exp_first4);
    int vcount, n_sent, done_c, first_c, bit_errs, sent_errs, proto_errs, q_under;
    int exp_frames, exp_bits, exp_done, idx, limit;
    logic [3:0] first4;
    logic [0:0] exp_b;
    bit ended;

    if (abort_at >= 0) begin
      exp_bits   = abort_at + 1;
      exp_frames = (abort_at + 1) / 2048;
      exp_done   = -1;
    end else begin
      exp_frames = (cnt != 0) ? cnt : stop_at / 2048 + 1;
      exp_bits   = exp_frames * 2048;
      exp_done   = exp_bits + 1;
    end
    exp_q.delete();
    vcount = 0; n_sent = 0; done_c = -1; first_c = -1;
    bit_errs = 0; sent_errs = 0; proto_errs = 0; q_under = 0;
    first4 = '0; ended = 1'b0;
    limit = exp_bits + 40;

    @(negedge clk);
    start      = 1'b1;
    stop       = 1'b1;   // stop in the start cycle must be dropped
    slos_count = CNT_W'(cnt);
    slos_sel   = sel0;

    for (int c = 1; c <= limit && !ended; c++) begin
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      idx   = -1;
      if (tx_valid === 1'b1) begin
        idx = vcount;
        if (first_c < 0) first_c = c;
        // slos_sel still holds the value sampled on the edge that launched this bit
        if (idx % 2048 == 0)
          for (int i = 0; i < 2048; i++) exp_q.push_back(golden[i] ^ slos_sel);
        if (exp_q.size() == 0) q_under++;
        else begin
          exp_b = exp_q.pop_front();
          if (data_out !== exp_b) bit_errs++;
        end
        if (idx < 4) first4[3-idx] = data_out;
        if (slos_sent !== (idx % 2048 == 2047)) sent_errs++;
        vcount++;
      end else if (slos_sent !== 1'b0) sent_errs++;
      if (slos_sent === 1'b1) n_sent++;
      if (tx_valid !== (c <= exp_bits)) proto_errs++;
      if (busy !== (c <= exp_bits)) proto_errs++;
      if (done !== (c == exp_done)) proto_errs++;
      if (done === 1'b1) begin
        if (done_c < 0) done_c = c;
        ended = 1'b1;
      end
      if (abort_at >= 0 && c == exp_bits + 1) begin
        check({name, ".abort_tx_valid"}, tx_valid, 0);
        check({name, ".abort_busy"},     busy,     0);
        check({name, ".abort_done"},     done,     0);
      end
      if (!ended) begin
        if (rand_sel) slos_sel = 1'($urandom_range(0, 1));
        start = (c < exp_bits) && ($urandom_range(0, 7) == 0);
        if (cnt == 0) stop = (idx >= 0) && (idx == stop_at);
        else          stop = ($urandom_range(0, 15) == 0);
        if (abort_at >= 0 && c == exp_bits)     enable = 1'b0;
        if (abort_at >= 0 && c == exp_bits + 5) enable = 1'b1;
      end
    end
    start  = 1'b0;
    stop   = 1'b0;
    enable = 1'b1;

    check({name, ".first_valid_cycle"}, first_c, 1);
    check({name, ".valid_bits"},        vcount, exp_bits);
    check({name, ".slos_sent_count"},   n_sent, exp_frames);
    check({name, ".done_cycle"},        done_c, exp_done);
    check({name, ".bit_errors"},        bit_errs, 0);
    check({name, ".sent_position_errors"}, sent_errs, 0);
    check({name, ".valid_busy_done_errors"}, proto_errs, 0);
    check({name, ".extra_valid_bits"},  q_under, 0);
    if (exp_first4 >= 0) check({name, ".bits0_3"}, first4, exp_first4);
  endtask

  initial begin
    build_golden();

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset  = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    stop = 1'b1;          // stop while idle is ignored
    @(negedge clk);
    stop = 1'b0;
    check_idle_outputs("idle_stop");

    burst("slos1_single",     1, 1'b0, 1'b0, -1,          -1,  4'b0010);
    burst("slos2_single",     1, 1'b1, 1'b0, -1,          -1,  4'b1101);
    burst("count3_rand_sel",  3, 1'($urandom_range(0, 1)), 1'b1, -1, -1, -1);
    burst("cont_stop_f2",     0, 1'b0, 1'b1, 2048 + 100,  -1,  -1);
    burst("cont_stop_last",   0, 1'b1, 1'b1, 2047,        -1,  4'b1101);
    burst("enable_abort",     2, 1'b0, 1'b0, -1,          500, 4'b0010);
    burst("after_abort",      1, 1'b0, 1'b0, -1,          -1,  4'b0010);

    // Asynchronous reset in the middle of a frame
    @(negedge clk);
    start      = 1'b1;
    slos_count = CNT_W'(2);
    slos_sel   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (700) @(negedge clk);
    check({"midframe", ".tx_valid_before_reset"}, tx_valid, 1);
    #2 reset = 1'b0;
    #1 check_idle_outputs("async_reset");
    repeat (3) begin
      @(negedge clk);
      check_idle_outputs("held_reset");
    end
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_release");

    burst("post_reset",       1, 1'b0, 1'b0, -1,          -1,  4'b0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
